serial_deser_rx: RTL
====================

Name: serial_deser_rx

Overview:
Serial-to-parallel receiver for the front-end serial link. Reassembles the LSB-first bit stream that the shift-register serializer produces into WIDTH-bit words. Aligns to word boundaries by hunting for a sync word. Delivers data words with a one-cycle valid strobe to downstream frame-building logic, and monitors the periodic sync word to detect loss of alignment.

Parameters:
WIDTH, 8, bits per serial word.
SYNC_WORD, 8'hBC, alignment pattern that opens every frame; WIDTH bits wide.
FRAME_WORDS, 4, number of data words following each sync word; must be at least 1.
MAX_MISS, 2, consecutive sync-slot mismatches that drop lock; must be at least 1.

Ports:
clk  input  1  link bit clock; all logic on posedge; one serial bit sampled per rising edge.
reset  input  1  asynchronous, active-low reset.
serial_in  input  1  serial data, LSB of each word first.
data_out  output  WIDTH  last received data word.
data_valid  output  1  one-cycle pulse when data_out is updated.
word_index  output  clog2(FRAME_WORDS)+1  position of data_out within its frame, 0..FRAME_WORDS-1.
locked  output  1  high while aligned.
sync_err  output  1  one-cycle pulse when a sync slot mismatches.

Behaviour:
- Reset (reset=0, asynchronous), held until reset returns high:
  - data_out=0, data_valid=0, word_index=0, locked=0, sync_err=0.
  - Internal shift register sr=0, bit_cnt=0, word_idx=0, miss_cnt=0.
  - State=SEARCH.
- Shift register, every posedge: sr <= {serial_in, sr[WIDTH-1:1]}. The first bit received lands in sr[0] after WIDTH shifts. "nxt" denotes this next-value.
- Frame format on the line: SYNC_WORD, then FRAME_WORDS data words, then SYNC_WORD again, repeating with no gaps.
- State SEARCH:
  - Compares nxt to SYNC_WORD at every edge (bit-granular hunt).
  - On a match at an edge: go to LOCKED, set locked=1, bit_cnt=0, word_idx=0, miss_cnt=0.
  - No data_valid and no sync_err are produced while in SEARCH.
- State LOCKED:
  - bit_cnt increments each edge and wraps at WIDTH-1 to 0. A word completes on the edge where bit_cnt==WIDTH-1.
  - If the word completes with word_idx<FRAME_WORDS:
    - data_out<=nxt, word_index<=word_idx, data_valid<=1, word_idx++.
    - Latency: data_out and data_valid become visible immediately after the edge that samples the word's last (MSB) bit.
  - If the word completes with word_idx==FRAME_WORDS (sync slot): word_idx<=0, no data_valid.
    - nxt==SYNC_WORD: miss_cnt<=0.
    - Mismatch: sync_err<=1 for one cycle, miss_cnt++.
    - If the incremented miss_cnt equals MAX_MISS: go to SEARCH, locked<=0, miss_cnt<=0.
- data_valid and sync_err are high for exactly one cycle. At all other times they are 0.
- data_out holds its value between strobes and across loss of lock.
- A data word that happens to equal SYNC_WORD while LOCKED is passed through as data. Realignment is never triggered while LOCKED.
- Reset asserted mid-word or mid-frame aborts immediately. No partial word is ever emitted. After release, the block re-hunts from SEARCH.
- MAX_MISS=1: the first sync mismatch both pulses sync_err and drops lock on the same edge.

Test Plan:
- Reset: hold reset=0 for 5 clocks with random serial_in -> all outputs 0, locked=0, no strobes.
- Acquire lock:
  - Stimulus: 3 random bits, then frame BC, 11, 22, 33, 44, then BC (LSB-first).
  - locked rises on the edge that samples the MSB of the first BC.
  - data_valid pulses 4 times, each WIDTH=8 clocks apart.
  - data_out/word_index = 11/0, 22/1, 33/2, 44/3.
  - No sync_err.
- Data equal to sync: frame BC, BC, 5A, BC, A5 -> all 4 data words delivered (BC at index 0, BC at index 2), locked stays 1.
- Single sync miss:
  - Stimulus: locked link, one sync slot replaced by 00.
  - sync_err pulses once, locked stays 1, data words in the following frame still delivered.
  - The next valid BC clears the miss count.
- Loss of lock: two consecutive sync slots = 00 -> sync_err pulses twice, locked falls on the second slot's last edge, then no data_valid until the next BC is found.
- Reset mid-word: assert reset after 3 bits of data word 22 -> data_valid never pulses for 22, locked=0 after release, relocks on the next BC.

Source files
------------

// File: rtl/serial_deser_rx_if.sv
// Bundle of the serial receiver's line input and word-side outputs.
// master: the receiver itself (samples the line, drives the word outputs).
// slave:  the link/consumer side (drives the line, observes the words).
interface serial_deser_rx_if #(
    parameter int WIDTH       = 8,
    parameter int FRAME_WORDS = 4
);
    localparam int IDX_W = $clog2(FRAME_WORDS) + 1;

    logic             serial_in;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic [IDX_W-1:0] word_index;
    logic             locked;
    logic             sync_err;

    modport master (
        input  serial_in,
        output data_out,
        output data_valid,
        output word_index,
        output locked,
        output sync_err
    );

    modport slave (
        output serial_in,
        input  data_out,
        input  data_valid,
        input  word_index,
        input  locked,
        input  sync_err
    );
endinterface

// File: rtl/serial_deser_rx.sv
// Serial-to-parallel receiver: hunts bit-by-bit for the sync word, then
// slices the LSB-first stream into WIDTH-bit words, emits FRAME_WORDS data
// words per frame and watches each sync slot, dropping lock after MAX_MISS
// consecutive bad sync slots.
module serial_deser_rx #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD   = 8'hBC,
    parameter int               FRAME_WORDS = 4,
    parameter int               MAX_MISS    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_deser_rx_if.master     bus
);
    localparam int IDX_W  = $clog2(FRAME_WORDS) + 1;
    localparam int BIT_W  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int MISS_W = $clog2(MAX_MISS + 1);

    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Only the WIDTH-1 most recent bits need storing: the oldest bit of the
    // full window falls off on the very edge that would read it.
    logic [WIDTH-2:0]  hist_q, hist_d;
    logic [WIDTH-1:0]  nxt;
    logic [0:0]        state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]  word_idx_q, word_idx_d;
    logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [MISS_W-1:0] miss_inc;
    logic [WIDTH-1:0]  data_out_q, data_out_d;
    logic [IDX_W-1:0]  word_index_q, word_index_d;
    logic              data_valid_q, data_valid_d;
    logic              locked_q, locked_d;
    logic              sync_err_q, sync_err_d;

    assign nxt      = {bus.serial_in, hist_q};
    assign miss_inc = miss_cnt_q + MISS_W'(1);

    // Next-state logic: sync hunt, word slicing, sync-slot monitoring.
    always_comb begin
        hist_d       = nxt[WIDTH-1:1];
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        word_idx_d   = word_idx_q;
        miss_cnt_d   = miss_cnt_q;
        data_out_d   = data_out_q;
        word_index_d = word_index_q;
        data_valid_d = 1'b0;
        locked_d     = locked_q;
        sync_err_d   = 1'b0;

        if (state_q == ST_SEARCH) begin
            if (nxt == SYNC_WORD) begin
                state_d    = ST_LOCKED;
                locked_d   = 1'b1;
                bit_cnt_d  = '0;
                word_idx_d = '0;
                miss_cnt_d = '0;
            end
        end else begin
            if (bit_cnt_q == BIT_W'(WIDTH - 1)) begin
                bit_cnt_d = '0;
                if (word_idx_q < IDX_W'(FRAME_WORDS)) begin
                    data_out_d   = nxt;
                    word_index_d = word_idx_q;
                    data_valid_d = 1'b1;
                    word_idx_d   = word_idx_q + IDX_W'(1);
                end else begin
                    // Sync slot: never re-aligns here, only counts misses.
                    word_idx_d = '0;
                    if (nxt == SYNC_WORD) begin
                        miss_cnt_d = '0;
                    end else begin
                        sync_err_d = 1'b1;
                        if (miss_inc == MISS_W'(MAX_MISS)) begin
                            state_d    = ST_SEARCH;
                            locked_d   = 1'b0;
                            miss_cnt_d = '0;
                        end else begin
                            miss_cnt_d = miss_inc;
                        end
                    end
                end
            end else begin
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
        end
    end

    // State and output registers; reset aborts any partial word at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q       <= '0;
            state_q      <= ST_SEARCH;
            bit_cnt_q    <= '0;
            word_idx_q   <= '0;
            miss_cnt_q   <= '0;
            data_out_q   <= '0;
            word_index_q <= '0;
            data_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            hist_q       <= hist_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            word_idx_q   <= word_idx_d;
            miss_cnt_q   <= miss_cnt_d;
            data_out_q   <= data_out_d;
            word_index_q <= word_index_d;
            data_valid_q <= data_valid_d;
            locked_q     <= locked_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.word_index = word_index_q;
    assign bus.data_valid = data_valid_q;
    assign bus.locked     = locked_q;
    assign bus.sync_err   = sync_err_q;
endmodule
